// File: rtl/hazard_scoreboard.sv
// Register-pending scoreboard for a classic 5-stage MIPS-style pipeline.
// Generates D-stage stalls from per-GPR Tnew counters and a mul/div busy timer.
module hazard_scoreboard #(
   parameter int NREG     = 32,
   parameter int TW       = 2,
   parameter int MULT_CYC = 5,
   parameter int DIV_CYC  = 10,
   parameter int SCW      = 16
) (
   input  logic                    clk,
   input  logic                    reset,
   input  logic                    d_valid,
   input  logic [$clog2(NREG)-1:0] d_rs,
   input  logic [$clog2(NREG)-1:0] d_rt,
   input  logic [TW-1:0]           d_tuse_rs,
   input  logic [TW-1:0]           d_tuse_rt,
   input  logic                    d_wr_en,
   input  logic [$clog2(NREG)-1:0] d_wr_addr,
   input  logic [TW-1:0]           d_tnew,
   input  logic                    d_md_start,
   input  logic                    d_md_is_div,
   input  logic                    d_md_use,
   input  logic                    flush,
   output logic                    stall,
   output logic                    stall_rs,
   output logic                    stall_rt,
   output logic                    stall_md,
   output logic                    md_busy,
   output logic [SCW-1:0]          stall_count
);

   localparam int AW   = $clog2(NREG);
   localparam int MAXC = (DIV_CYC > MULT_CYC) ? DIV_CYC : MULT_CYC;
   localparam int MW   = $clog2(MAXC + 2);
   localparam logic [MW-1:0] MULT_LD = MW'(MULT_CYC + 1);
   localparam logic [MW-1:0] DIV_LD  = MW'(DIV_CYC + 1);

   logic [TW-1:0] cnt [NREG];
   logic [TW-1:0] cnt_rs;
   logic [TW-1:0] cnt_rt;
   logic [MW-1:0] md_cnt;
   logic          issue;

   assign cnt_rs = cnt[d_rs];
   assign cnt_rt = cnt[d_rt];

   always_comb begin
      stall_rs = d_valid & (d_rs != '0) & (d_tuse_rs < cnt_rs);
      stall_rt = d_valid & (d_rt != '0) & (d_tuse_rt < cnt_rt);
      md_busy  = (md_cnt != '0);
      stall_md = d_valid & d_md_use & md_busy;
      stall    = stall_rs | stall_rt | stall_md;
      issue    = d_valid & ~stall;
   end

   // Entry 0 is a constant-zero flop so $0 reads never see a pending write.
   always_ff @(posedge clk) begin
      for (int r = 0; r < NREG; r++) begin
         if (reset || flush || r == 0)
            cnt[r] <= '0;
         else if (issue && d_wr_en && d_wr_addr == AW'(r))
            cnt[r] <= d_tnew;
         else if (cnt[r] != '0)
            cnt[r] <= cnt[r] - TW'(1);
      end
   end

   always_ff @(posedge clk) begin
      if (reset)
         md_cnt <= '0;
      else if (issue && d_md_start)
         md_cnt <= d_md_is_div ? DIV_LD : MULT_LD;
      else if (md_cnt != '0)
         md_cnt <= md_cnt - MW'(1);
   end

   always_ff @(posedge clk) begin
      if (reset)
         stall_count <= '0;
      else if (stall && stall_count != '1)
         stall_count <= stall_count + SCW'(1);
   end

endmodule

// File: tb/tb_hazard_scoreboard.sv
// Directed vector bench for hazard_scoreboard: one table entry per cycle,
// plus a mid-divide reset sequence and a 2-bit saturating counter copy.
module tb_hazard_scoreboard;

   logic       clk = 1'b0;
   logic       reset;
   logic       d_valid;
   logic [4:0] d_rs, d_rt, d_wr_addr;
   logic [1:0] d_tuse_rs, d_tuse_rt, d_tnew;
   logic       d_wr_en, d_md_start, d_md_is_div, d_md_use, flush;
   logic       stall, stall_rs, stall_rt, stall_md, md_busy;
   logic [15:0] stall_count;
   logic       s_stall, s_rs, s_rt, s_md, s_busy;
   logic [1:0] s_count;

   int total = 0;
   int bad   = 0;

   always #5 clk = ~clk;

   hazard_scoreboard u_dut (
      .clk(clk), .reset(reset), .d_valid(d_valid),
      .d_rs(d_rs), .d_rt(d_rt),
      .d_tuse_rs(d_tuse_rs), .d_tuse_rt(d_tuse_rt),
      .d_wr_en(d_wr_en), .d_wr_addr(d_wr_addr), .d_tnew(d_tnew),
      .d_md_start(d_md_start), .d_md_is_div(d_md_is_div),
      .d_md_use(d_md_use), .flush(flush),
      .stall(stall), .stall_rs(stall_rs), .stall_rt(stall_rt),
      .stall_md(stall_md), .md_busy(md_busy),
      .stall_count(stall_count)
   );

   hazard_scoreboard #(.SCW(2)) u_sat (
      .clk(clk), .reset(reset), .d_valid(d_valid),
      .d_rs(d_rs), .d_rt(d_rt),
      .d_tuse_rs(d_tuse_rs), .d_tuse_rt(d_tuse_rt),
      .d_wr_en(d_wr_en), .d_wr_addr(d_wr_addr), .d_tnew(d_tnew),
      .d_md_start(d_md_start), .d_md_is_div(d_md_is_div),
      .d_md_use(d_md_use), .flush(flush),
      .stall(s_stall), .stall_rs(s_rs), .stall_rt(s_rt),
      .stall_md(s_md), .md_busy(s_busy),
      .stall_count(s_count)
   );

   typedef struct {
      logic       v;
      logic [4:0] rs;
      logic [1:0] trs;
      logic [4:0] rt;
      logic [1:0] trt;
      logic       we;
      logic [4:0] wa;
      logic [1:0] tn;
      logic       mds, mdiv, mdu, fl;
      logic       srs, srt, smd, busy;
      int         sc;
   } vec_t;

   vec_t vecs[$];

   function automatic vec_t op(
      input logic [4:0] rs, input logic [1:0] trs,
      input logic [4:0] rt, input logic [1:0] trt,
      input logic we, input logic [4:0] wa,
      input logic [1:0] tn, input logic [2:0] md);
      vec_t x;
      x.v = 1'b1; x.rs = rs; x.trs = trs; x.rt = rt; x.trt = trt;
      x.we = we; x.wa = wa; x.tn = tn;
      x.mds = md[2]; x.mdiv = md[1]; x.mdu = md[0]; x.fl = 1'b0;
      x.srs = 1'b0; x.srt = 1'b0; x.smd = 1'b0; x.busy = 1'b0;
      x.sc = 0;
      return x;
   endfunction

   task automatic add(input vec_t x, input logic [3:0] e, input int sc);
      x.srs = e[3]; x.srt = e[2]; x.smd = e[1]; x.busy = e[0];
      x.sc = sc;
      vecs.push_back(x);
   endtask

   task automatic drive(input vec_t x);
      d_valid = x.v; d_rs = x.rs; d_tuse_rs = x.trs;
      d_rt = x.rt; d_tuse_rt = x.trt;
      d_wr_en = x.we; d_wr_addr = x.wa; d_tnew = x.tn;
      d_md_start = x.mds; d_md_is_div = x.mdiv;
      d_md_use = x.mdu; flush = x.fl;
   endtask

   task automatic chk(input string nm, input int act, input int exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0d want %0d", nm, act, exp);
      end
   endtask

   task automatic chk_all(input string tag, input logic srs,
                          input logic srt, input logic smd,
                          input logic busy, input int sc);
      int sat;
      sat = (sc > 3) ? 3 : sc;
      chk({tag, " stall"}, int'(stall), int'(srs | srt | smd));
      chk({tag, " stall_rs"}, int'(stall_rs), int'(srs));
      chk({tag, " stall_rt"}, int'(stall_rt), int'(srt));
      chk({tag, " stall_md"}, int'(stall_md), int'(smd));
      chk({tag, " md_busy"}, int'(md_busy), int'(busy));
      chk({tag, " stall_count"}, int'(stall_count), sc);
      chk({tag, " sat_count"}, int'(s_count), sat);
   endtask

   initial begin
      vec_t lw8, addu, beq8, beq8t, ori11, mflo, mfhi, div_i, mult_i, x;

      lw8    = op(0, 3, 0, 3, 1, 8, 2, 3'b000);
      addu   = op(8, 1, 9, 1, 1, 10, 1, 3'b000);
      beq8   = op(8, 0, 0, 0, 0, 0, 0, 3'b000);
      beq8t  = op(0, 3, 8, 0, 0, 0, 0, 3'b000);
      ori11  = op(0, 3, 0, 3, 1, 11, 1, 3'b000);
      mflo   = op(0, 3, 0, 3, 1, 2, 1, 3'b001);
      mfhi   = op(0, 3, 0, 3, 1, 3, 1, 3'b001);
      div_i  = op(4, 1, 5, 1, 0, 0, 0, 3'b111);
      mult_i = op(4, 1, 5, 1, 0, 0, 0, 3'b101);

      add(op(29, 1, 0, 3, 1, 8, 2, 3'b000), 4'b0000, 0);
      add(addu, 4'b1000, 0);
      add(addu, 4'b0000, 1);
      add(lw8, 4'b0000, 1);
      add(beq8, 4'b1000, 1);
      add(beq8, 4'b1000, 2);
      add(beq8, 4'b0000, 3);
      add(lw8, 4'b0000, 3);
      add(ori11, 4'b0000, 3);
      add(beq8t, 4'b0100, 3);
      add(beq8t, 4'b0000, 4);
      add(lw8, 4'b0000, 4);
      add(op(0, 1, 0, 3, 1, 8, 1, 3'b000), 4'b0000, 4);
      add(op(29, 1, 8, 2, 0, 0, 0, 3'b000), 4'b0000, 4);
      add(div_i, 4'b0000, 4);
      for (int k = 0; k < 11; k++) add(mflo, 4'b0011, 4 + k);
      add(mflo, 4'b0000, 15);
      add(mult_i, 4'b0000, 15);
      for (int k = 0; k < 6; k++) add(mfhi, 4'b0011, 15 + k);
      add(mfhi, 4'b0000, 21);
      add(div_i, 4'b0000, 21);
      add(op(9, 1, 10, 1, 1, 12, 1, 3'b000), 4'b0001, 21);
      x = op(29, 1, 0, 3, 1, 9, 2, 3'b000);
      x.fl = 1'b1;
      add(x, 4'b0001, 21);
      add(op(9, 0, 0, 3, 0, 0, 0, 3'b000), 4'b0001, 21);
      add(op(29, 1, 0, 3, 1, 0, 2, 3'b000), 4'b0001, 21);
      add(op(0, 0, 0, 0, 0, 0, 0, 3'b000), 4'b0001, 21);

      reset = 1'b1;
      x = op(8, 0, 8, 0, 1, 8, 2, 3'b001);
      drive(x);
      @(posedge clk); #1;
      @(posedge clk); #1;
      @(negedge clk);
      chk_all("reset", 1'b0, 1'b0, 1'b0, 1'b0, 0);
      @(posedge clk); #1;
      reset = 1'b0;

      for (int i = 0; i < vecs.size(); i++) begin
         drive(vecs[i]);
         @(negedge clk);
         chk_all($sformatf("v%0d", i), vecs[i].srs, vecs[i].srt,
                 vecs[i].smd, vecs[i].busy, vecs[i].sc);
         @(posedge clk); #1;
      end

      // Reset mid-divide while a load tries to issue.
      drive(lw8);
      reset = 1'b1;
      @(negedge clk);
      chk("pre_reset md_busy", int'(md_busy), 1);
      @(posedge clk); #1;
      reset = 1'b0;
      x = beq8;
      x.mdu = 1'b1;
      drive(x);
      @(negedge clk);
      chk_all("post_reset", 1'b0, 1'b0, 1'b0, 1'b0, 0);
      @(posedge clk); #1;

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/hazard_scoreboard.md
HAZARD_SCOREBOARD -- requirements
Module: hazard_scoreboard

Interface
REQ-001 SHALL provide parameter NREG, default 32, meaning number of GPRs tracked; register 0 is never pending.
REQ-002 SHALL provide parameter TW, default 2, meaning width of Tuse/Tnew fields.
REQ-003 SHALL provide parameter MULT_CYC, default 5, meaning mult/multu busy cycles after the start cycle.
REQ-004 SHALL provide parameter DIV_CYC, default 10, meaning div/divu busy cycles after the start cycle.
REQ-005 SHALL provide parameter SCW, default 16, meaning stall-counter width.
REQ-006 clk  in  1  single clock, rising edge; synchronous, active-high reset.
REQ-007 reset  in  1  synchronous active-high reset.
REQ-008 d_valid  in  1  D stage holds a real instruction.
REQ-009 d_rs, d_rt  in  log2(NREG) each  D source register numbers.
REQ-010 d_tuse_rs, d_tuse_rt  in  TW each  cycles until operand needed; all-ones = operand unused.
REQ-011 d_wr_en  in  1  D instruction writes the GPR file.
REQ-012 d_wr_addr  in  log2(NREG)  D destination register.
REQ-013 d_tnew  in  TW  producer Tnew on entering E (load 2, cal_r/cal_i/mf 1, link 0).
REQ-014 d_md_start  in  1  D instruction is mult/multu/div/divu.
REQ-015 d_md_is_div  in  1  qualifies d_md_start as a divide.
REQ-016 d_md_use  in  1  D instruction is md/mf/mt.
REQ-017 flush  in  1  clear all GPR pending state.
REQ-018 stall  out  1  freeze PC/F-D, insert bubble into E.
REQ-019 stall_rs, stall_rt, stall_md  out  1 each  stall causes.
REQ-020 md_busy  out  1  multiply/divide unit occupied.
REQ-021 stall_count  out  SCW  saturating count of stall cycles.

Function
REQ-022 SHALL keep a TW-bit pending counter cnt[r] per register r in 1..NREG-1; cnt[0] SHALL read 0 always.
REQ-023 issue = d_valid & ~stall; SHALL be internal and combinational.
REQ-024 Each cycle every nonzero cnt[r] SHALL decrement by 1; zero counters SHALL hold.
REQ-025 On issue with d_wr_en and d_wr_addr != 0, cnt[d_wr_addr] SHALL load d_tnew, overriding that register's decrement in the same cycle.
REQ-026 stall_rs = d_valid & (d_rs != 0) & (d_tuse_rs < cnt[d_rs]); stall_rt likewise with d_rt/d_tuse_rt; unsigned compare.
REQ-027 md_cnt (width fits DIV_CYC+1) SHALL load MULT_CYC+1 or DIV_CYC+1 on issue with d_md_start (per d_md_is_div), else decrement while nonzero.
REQ-028 md_busy = (md_cnt != 0); stall_md = d_valid & d_md_use & md_busy.
REQ-029 stall = stall_rs | stall_rt | stall_md, purely combinational from current state and D inputs, zero-cycle latency.
REQ-030 While stalled nothing loads; counters keep decrementing so stalls self-release.
REQ-031 flush SHALL zero all cnt[] next cycle, taking priority over a simultaneous load; md_cnt SHALL be unaffected.
REQ-032 stall_count SHALL increment each cycle stall=1 and saturate at 2^SCW-1.

Reset
REQ-033 reset SHALL zero all cnt[], md_cnt and stall_count on the next rising edge, overriding issue, flush and decrement.
REQ-034 After reset, stall, stall_rs, stall_rt, stall_md and md_busy SHALL be 0 for any D inputs.
REQ-035 Reset mid-divide SHALL clear md_busy in one cycle.

Verification
REQ-036 lw $8 issues (tnew=2); next cycle addu using $8 (tuse_rs=1) -> stall=1, stall_rs=1 for 1 cycle, then issue; stall_count=1.
REQ-037 lw $8 then beq $8 (tuse=0) -> stall 2 cycles; with one independent instr between -> stall 1 cycle.
REQ-038 Back-to-back writers: lw $8 then ori $8 issued -> cnt[8]=1 after ori; dependent sw rt=$8 (tuse_rt=2) -> no stall.
REQ-039 div issued, then mflo next cycle -> stall_md=1 for 11 cycles (DIV_CYC+1); mult -> 6; nonmd instr never stalls on md_busy.
REQ-040 flush and issue of lw $9 same cycle -> cnt[9]=0; reset during div -> md_busy=0 next cycle; writes to $0 never stall; stall_count saturates with SCW=2 at 3.
